// File: rtl/ac_stim_if.sv
// ac_stim_if: valid/ready signed sample stream from the DDS toward the DAC.
interface ac_stim_if #(
   parameter int OUT_W = 12
);
   logic             s_valid;
   logic             s_ready;
   logic [OUT_W-1:0] s_data;

   modport master (output s_valid, output s_data, input s_ready);
   modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/ac_stim_dds.sv
// ac_stim_dds: stepped-sweep DDS sine source, quarter-wave LUT, dwell FSM.
// Optional AC_STIM_DITHER_EN adds 1-LSB LFSR dither to each sample.
module ac_stim_dds #(
   parameter int PHASE_W = 24,
   parameter int OUT_W   = 12,
   parameter int LUT_AW  = 8,
   parameter int DWELL_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               abort,
   input  logic [PHASE_W-1:0] f_start,
   input  logic [PHASE_W-1:0] f_step,
   input  logic [7:0]         n_steps,
   input  logic [DWELL_W-1:0] dwell,
   input  logic [2:0]         amp_shift,
   ac_stim_if.master          st,
   output logic               busy,
   output logic [7:0]         step_idx,
   output logic               step_strobe,
   output logic               done
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam real PI = 3.14159265358979323846;
   localparam logic signed [OUT_W-1:0] MAXPOS = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic [OUT_W-1:0] LSB = OUT_W'(1);

   function automatic int lut_val(int k);
      real a;
      real x;
      a = (2.0 ** (OUT_W - 1)) - 1.0;
      x = a * $sin(2.0 * PI * (real'(k) + 0.5) / (2.0 ** (LUT_AW + 2)));
      return $rtoi(x + 0.5);
   endfunction

   state_t                  state, state_nx;
   logic                    pend, go, xfer, last_dw, last_st;
   logic [PHASE_W-1:0]      phase, ftw, fstep_r, phase_nx;
   logic [DWELL_W-1:0]      dcnt, dlast;
   logic [7:0]              nlast;
   logic [2:0]              amp_r;
   logic [OUT_W-1:0]        data_q, sample;
   logic [LUT_AW+1:0]       top;
   logic [LUT_AW-1:0]       idx;
   logic signed [OUT_W-1:0] mag, sine, shifted;
   logic [OUT_W-2:0]        lut [2**LUT_AW];

   for (genvar g = 0; g < 2**LUT_AW; g++) begin : g_lut
      localparam int V = lut_val(g);
      assign lut[g] = V[OUT_W-2:0];
   end

   // pend marks the cycle between config latch and the first sample load
   assign go       = (state == IDLE) && start && !abort && !pend;
   assign xfer     = (state == RUN) && st.s_ready && !abort;
   assign last_dw  = (dcnt == dlast);
   assign last_st  = (step_idx == nlast);
   assign phase_nx = phase + ftw;
   assign st.s_data = data_q;

`ifdef AC_STIM_DITHER_EN
   logic [15:0] lfsr;
   logic        fb, dbit;

   assign fb   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
   assign dbit = (state == RUN) ? fb : lfsr[0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    lfsr <= 16'hACE1;
      else if (go)   lfsr <= 16'hACE1;
      else if (xfer) lfsr <= {lfsr[14:0], fb};
   end
`endif

   always_comb begin
      top     = (state == RUN) ? phase_nx[PHASE_W-1 -: LUT_AW+2] : '0;
      idx     = top[LUT_AW-1:0] ^ {LUT_AW{top[LUT_AW]}};
      mag     = $signed({1'b0, lut[idx]});
      sine    = top[LUT_AW+1] ? -mag : mag;
      shifted = sine >>> amp_r;
      sample  = shifted;
`ifdef AC_STIM_DITHER_EN
      if (dbit && (shifted != MAXPOS)) sample = shifted + LSB;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (pend && !abort) state_nx = RUN;
         RUN: begin
            if (abort)
               state_nx = IDLE;
            else if (xfer && last_dw && last_st)
               state_nx = DONE;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      busy       = 1'b0;
      st.s_valid = 1'b0;
      done       = 1'b0;
      unique case (state)
         RUN: begin
            busy       = 1'b1;
            st.s_valid = 1'b1;
         end
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend        <= 1'b0;
         phase       <= '0;
         ftw         <= '0;
         fstep_r     <= '0;
         dcnt        <= '0;
         dlast       <= '0;
         nlast       <= '0;
         amp_r       <= '0;
         step_idx    <= '0;
         step_strobe <= 1'b0;
         data_q      <= '0;
      end else begin
         pend        <= go;
         step_strobe <= 1'b0;
         if (go) begin
            fstep_r  <= f_step;
            amp_r    <= amp_shift;
            nlast    <= (n_steps == 8'd0) ? 8'd0 : n_steps - 8'd1;
            dlast    <= (dwell == '0) ? '0 : dwell - DWELL_W'(1);
            ftw      <= f_start;
            phase    <= '0;
            dcnt     <= '0;
            step_idx <= '0;
         end else if (pend && !abort) begin
            data_q <= sample;
         end else if (xfer) begin
            phase  <= phase_nx;
            data_q <= sample;
            if (!last_dw) begin
               dcnt <= dcnt + DWELL_W'(1);
            end else if (!last_st) begin
               ftw         <= ftw + fstep_r;
               step_idx    <= step_idx + 8'd1;
               dcnt        <= '0;
               step_strobe <= 1'b1;
            end
         end
      end
   end
endmodule
